mips_cpu_lsu: RTL
=================

Name: mips_cpu_lsu

Overview:
Load/store unit directly upstream of the data memory. Accepts one byte/half/word load or store per transaction from the CPU execute stage and checks alignment. Converts the access into a word-aligned memory access with byte enables and lane-replicated write data, then returns the extracted and extended load result. Handshakes with memory via waitrequest so that both zero-wait and stalled memories work.

Parameters:
TIMEOUT_CYCLES, 16, waitrequest cycles tolerated in ACCESS before abort (only with MIPS_CPU_LSU_TIMEOUT_EN); range 1..255

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  LSU can accept a request
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault)
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result (0 for stores/faults)
rsp_fault  out  1  misaligned/reserved-size/timeout, qualified by rsp_valid
mem_address  out  32  word-aligned byte address ({req_addr[31:2],2'b00})
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byteenable  out  4  active lanes, bit i = bits[8i+7:8i]
mem_writedata  out  32  lane-replicated store data
mem_readdata  in  32  memory read data, valid when waitrequest=0
mem_waitrequest  in  1  memory stall

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_read=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0.
- FSM IDLE/ACCESS/RESP. IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - If the request faults, go to RESP with fault=1. Fault cases: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - Otherwise go to ACCESS.
- ACCESS: req_ready=0. mem_read=!write, mem_write=write; address, byteenable and writedata held stable from latched values.
  - While mem_waitrequest=1, stay in ACCESS.
  - When mem_waitrequest=0, drop strobes next cycle. For loads, capture the extracted load data this cycle. Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE. A new request is accepted only in IDLE.
- Latency with zero wait: accept at edge N, mem strobe during cycle N+1, rsp_valid during cycle N+2. Each waitrequest cycle adds 1.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: byte = readdata >> (8*addr[1:0]), low 8 bits; half = readdata >> (8*addr[1:0]), low 16 bits; then sign/zero extend per req_signed. Word loads ignore req_signed.
- Stores: rsp_rdata=0. Faulted requests never assert mem_read or mem_write.
- rsp_rdata/rsp_fault hold until the next response; they are only meaningful with rsp_valid.
- Reset mid-ACCESS: strobes drop immediately (async). The transaction is lost and no response is issued.
- req_valid during ACCESS/RESP is ignored; the CPU holds it until it sees req_ready.

Optional Feature:
MIPS_CPU_LSU_TIMEOUT_EN
- Defined: an 8-bit counter clears on entry to ACCESS and increments per waitrequest=1 cycle. On reaching TIMEOUT_CYCLES, the strobes drop, the FSM goes to RESP with rsp_fault=1 and rsp_rdata=0.
- Undefined: there is no counter, and ACCESS waits indefinitely.

Decomposition:
- Package mips_cpu_lsu_pkg contains:
  - size enum (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10)
  - state enum (IDLE, ACCESS, RESP)
  - function is_misaligned(size, addr[1:0])
- Sub-module mips_cpu_lsu_lane: purely combinational; computes byteenable, replicated write data and the extracted/extended load value from size, signed, offset, wdata, readdata. Instantiated once in mips_cpu_lsu.

Test Plan:
- Store byte addr=0x00000103, wdata=0x000000AB, waitrequest=0 -> mem_address=0x00000100, byteenable=1000, writedata=0xABABABAB, mem_write 1 cycle, rsp_valid 2 cycles after accept, fault=0.
- Load half signed addr=0x00000202, readdata=0x8001_1234 -> byteenable=1100, rsp_rdata=0xFFFF8001; same with req_signed=0 -> 0x00008001.
- Load word addr=0x00000006 -> rsp_fault=1, rsp_rdata=0, mem_read never asserted, rsp_valid at cycle N+1.
- Load byte unsigned addr=0x1, readdata=0xDEADBEEF, waitrequest high 3 cycles -> strobes stable 4 cycles, rsp_rdata=0x000000BE, rsp_valid at N+5.
- rst_n low during ACCESS -> mem_read=0 immediately, req_ready=1 after release, no rsp_valid.
- TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> rsp_valid with rsp_fault=1 after 4 ACCESS cycles; without macro, the FSM remains in ACCESS.

Source files
------------

// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the MIPS CPU load/store unit.
package mips_cpu_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // True when the access cannot be issued: misaligned half/word or reserved size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return (offset != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_lane.sv
// Byte-lane steering: byte enables, replicated store data and extended load data.
module mips_cpu_lsu_lane
    import mips_cpu_lsu_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [1:0]        i_offset,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [BE_W-1:0]   o_byteenable_c,
    output logic [DATA_W-1:0] o_writedata_c,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [15:0] w_lane;

    assign w_lane = 16'(i_rdata >> {i_offset, 3'b000});

    always_comb begin
        o_byteenable_c = '0;
        o_writedata_c  = '0;
        o_rdata_c      = '0;
        case (i_size)
            SIZE_BYTE: begin
                o_byteenable_c = 4'b0001 << i_offset;
                o_writedata_c  = {4{i_wdata[7:0]}};
                o_rdata_c      = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
            end
            SIZE_HALF: begin
                o_byteenable_c = 4'b0011 << i_offset;
                o_writedata_c  = {2{i_wdata[15:0]}};
                o_rdata_c      = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            end
            SIZE_WORD: begin
                o_byteenable_c = 4'b1111;
                o_writedata_c  = i_wdata;
                o_rdata_c      = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit between CPU execute stage and a waitrequest-style data memory.
// Optional build macro MIPS_CPU_LSU_TIMEOUT_EN aborts stalled accesses after TIMEOUT_CYCLES.
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mips_cpu_lsu: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_size, r_off;
    logic        r_signed, r_write;
    logic        r_req_ready, r_rsp_valid, r_rsp_fault;
    logic [31:0] r_rsp_rdata;
    logic        r_mem_read, r_mem_write;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic        w_in_idle, w_accept, w_req_fault, w_mem_done, w_timeout;
    logic [1:0]  w_lane_size, w_lane_off;
    logic        w_lane_signed;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_rdata;

    assign w_in_idle   = (r_state == IDLE);
    assign w_accept    = w_in_idle && req_valid;
    assign w_req_fault = is_misaligned(req_size, req_addr[1:0]);
    assign w_mem_done  = (r_state == ACCESS) && !mem_waitrequest;

    // Lane logic sees the live request while idle and the latched one afterwards.
    assign w_lane_size   = w_in_idle ? req_size      : r_size;
    assign w_lane_off    = w_in_idle ? req_addr[1:0] : r_off;
    assign w_lane_signed = w_in_idle ? req_signed    : r_signed;

    mips_cpu_lsu_lane u_lane (
        .i_size         (w_lane_size),
        .i_signed       (w_lane_signed),
        .i_offset       (w_lane_off),
        .i_wdata        (req_wdata),
        .i_rdata        (mem_readdata),
        .o_byteenable_c (w_be),
        .o_writedata_c  (w_wdata),
        .o_rdata_c      (w_rdata)
    );

`ifdef MIPS_CPU_LSU_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (r_state == ACCESS && mem_waitrequest) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ACCESS) && mem_waitrequest &&
                       (8'(r_to_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = w_req_fault ? RESP : ACCESS;
            ACCESS:  if (w_mem_done || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size      <= '0;
            r_off       <= '0;
            r_signed    <= 1'b0;
            r_write     <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_size      <= req_size;
                r_off       <= req_addr[1:0];
                r_signed    <= req_signed;
                r_write     <= req_write;
                r_req_ready <= 1'b0;
                if (w_req_fault) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_fault <= 1'b1;
                    r_rsp_rdata <= '0;
                end else begin
                    r_mem_read  <= !req_write;
                    r_mem_write <= req_write;
                    r_mem_addr  <= {req_addr[31:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                end
            end else if (w_mem_done) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= 1'b0;
                r_rsp_rdata <= r_write ? 32'd0 : w_rdata;
            end else if (w_timeout) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= 1'b1;
                r_rsp_rdata <= '0;
            end else if (r_state == RESP) begin
                r_req_ready <= 1'b1;
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_fault      = r_rsp_fault;
    assign mem_address    = r_mem_addr;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_byteenable = r_mem_be;
    assign mem_writedata  = r_mem_wdata;

endmodule
